// File: rtl/manual_override_ctrl.sv
// Manual override controller: synchronizes and debounces two push buttons,
// runs an AUTO/MANUAL mode FSM and auto-releases manual mode after a
// period without button presses.
module manual_override_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TICKS_PER_SEC   = 100000000,
  parameter int unsigned TIMEOUT_SEC     = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_next,
  output logic       manual_override,
  output logic [1:0] manual_state,
  output logic       timeout_pulse
);

  localparam int unsigned DW = 24;
  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned SW = 8;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] SEC_LAST   = SW'((TIMEOUT_SEC == 0) ? 0 : TIMEOUT_SEC - 1);
  localparam logic [1:0] ST_RED    = 2'b00;
  localparam logic [1:0] ST_YELLOW = 2'b01;
  localparam logic [1:0] ST_GREEN  = 2'b10;

  typedef enum logic {AUTO = 1'b0, MANUAL = 1'b1} state_e;

  // bit 0 = btn_mode, bit 1 = btn_next
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    acc_q, acc_d, prev_q;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  logic [1:0]    evt;

  state_e        state_q, state_d;
  logic          override_q, override_d;
  logic [1:0]    mstate_q, mstate_d;
  logic          tpulse_q, tpulse_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] sec_q, sec_d;

  // Two-flop synchronizers, debounce counters and accepted levels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      acc_q   <= '0;
      prev_q  <= '0;
      for (int b = 0; b < 2; b++) cnt_q[b] <= '0;
    end else begin
      sync1_q <= {btn_next, btn_mode};
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      prev_q  <= acc_q;
      for (int b = 0; b < 2; b++) cnt_q[b] <= cnt_d[b];
    end
  end

  // Debounce: count while synced level disagrees with accepted level
  always_comb begin
    acc_d = acc_q;
    for (int b = 0; b < 2; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != acc_q[b]) begin
        if (cnt_q[b] == DB_LAST) begin
          acc_d[b] = ~acc_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + DW'(1);
        end
      end
    end
  end

  // Press events on accepted 0->1 only
  assign evt = acc_q & ~prev_q;

  // FSM state, output and timeout counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= AUTO;
      override_q <= 1'b0;
      mstate_q   <= ST_RED;
      tpulse_q   <= 1'b0;
      presc_q    <= '0;
      sec_q      <= '0;
    end else begin
      state_q    <= state_d;
      override_q <= override_d;
      mstate_q   <= mstate_d;
      tpulse_q   <= tpulse_d;
      presc_q    <= presc_d;
      sec_q      <= sec_d;
    end
  end

  // Next state: mode event beats next event, any event beats timeout
  always_comb begin
    state_d    = state_q;
    override_d = override_q;
    mstate_d   = mstate_q;
    tpulse_d   = 1'b0;
    presc_d    = '0;
    sec_d      = '0;
    case (state_q)
      AUTO: begin
        mstate_d = ST_RED;
        if (evt[0]) begin
          state_d    = MANUAL;
          override_d = 1'b1;
        end
      end
      MANUAL: begin
        if (evt[0]) begin
          state_d    = AUTO;
          override_d = 1'b0;
          mstate_d   = ST_RED;
        end else if (evt[1]) begin
          case (mstate_q)
            ST_RED:    mstate_d = ST_YELLOW;
            ST_YELLOW: mstate_d = ST_GREEN;
            default:   mstate_d = ST_RED;
          endcase
        end else if (TIMEOUT_SEC != 0) begin
          if (presc_q == PRESC_LAST) begin
            if (sec_q == SEC_LAST) begin
              state_d    = AUTO;
              override_d = 1'b0;
              mstate_d   = ST_RED;
              tpulse_d   = 1'b1;
            end else begin
              sec_d = sec_q + SW'(1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
            sec_d   = sec_q;
          end
        end
      end
      default: begin
        state_d    = AUTO;
        override_d = 1'b0;
        mstate_d   = ST_RED;
      end
    endcase
  end

  assign manual_override = override_q;
  assign manual_state    = mstate_q;
  assign timeout_pulse   = tpulse_q;

endmodule

// File: tb/tb_manual_override_ctrl.sv
// Directed bench for manual_override_ctrl with short debounce and timeout.
module tb_manual_override_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_next = 1'b0;
  logic       manual_override;
  logic [1:0] manual_state;
  logic       timeout_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int to_cnt = 0;
  int to_base;

  manual_override_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICKS_PER_SEC  (10),
    .TIMEOUT_SEC    (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_mode       (btn_mode),
    .btn_next       (btn_next),
    .manual_override(manual_override),
    .manual_state   (manual_state),
    .timeout_pulse  (timeout_pulse)
  );

  always #5 clk = ~clk;

  // Count every cycle in which timeout_pulse is high
  always @(negedge clk) if (timeout_pulse) to_cnt = to_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press one button: event lands on edge 7, then release and let it settle
  task automatic press(input bit mode, input bit nxt, input string tag,
                       input logic exp_ovr, input logic [1:0] exp_st);
    btn_mode = mode;
    btn_next = nxt;
    step(7);
    check_eq({tag, "_ovr"}, 32'(manual_override), 32'(exp_ovr));
    check_eq({tag, "_st"}, 32'(manual_state), 32'(exp_st));
    btn_mode = 1'b0;
    btn_next = 1'b0;
    step(6);
  endtask

  initial begin
    #1;
    check_eq("rst_async_ovr", 32'(manual_override), 32'd0);
    check_eq("rst_async_st", 32'(manual_state), 32'd0);
    step(2);
    reset = 1'b0;
    step(1);
    check_eq("rst_ovr", 32'(manual_override), 32'd0);
    check_eq("rst_st", 32'(manual_state), 32'd0);
    check_eq("rst_to", 32'(timeout_pulse), 32'd0);

    // Glitches of 3 cycles with 1-cycle gaps must be rejected
    for (int i = 0; i < 3; i++) begin
      btn_mode = 1'b1; step(3);
      btn_mode = 1'b0; step(1);
    end
    step(10);
    check_eq("glitch_ovr", 32'(manual_override), 32'd0);
    check_eq("glitch_st", 32'(manual_state), 32'd0);

    // Clean mode press: no change before edge 7, change at edge 7
    btn_mode = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      check_eq("lat_early", 32'(manual_override), 32'd0);
    end
    step(1);
    check_eq("lat_ovr", 32'(manual_override), 32'd1);
    check_eq("lat_st", 32'(manual_state), 32'd0);
    btn_mode = 1'b0;
    step(6);

    // Advance through the light states
    press(1'b0, 1'b1, "nxt1", 1'b1, 2'b01);
    press(1'b0, 1'b1, "nxt2", 1'b1, 2'b10);
    press(1'b0, 1'b1, "nxt3", 1'b1, 2'b00);
    press(1'b0, 1'b1, "nxt4", 1'b1, 2'b01);

    // Simultaneous events act as mode only
    press(1'b1, 1'b1, "both_exit", 1'b0, 2'b00);
    press(1'b1, 1'b1, "both_enter", 1'b1, 2'b00);
    press(1'b1, 1'b0, "mode_exit", 1'b0, 2'b00);

    // Next presses in AUTO are ignored
    press(1'b0, 1'b1, "auto_nxt1", 1'b0, 2'b00);
    press(1'b0, 1'b1, "auto_nxt2", 1'b0, 2'b00);

    // Timeout after 30 idle cycles in MANUAL
    to_base = to_cnt;
    btn_mode = 1'b1; step(7);
    check_eq("to_enter", 32'(manual_override), 32'd1);
    btn_mode = 1'b0; step(6);
    step(23);
    check_eq("to_pre_ovr", 32'(manual_override), 32'd1);
    check_eq("to_pre_pulse", 32'(timeout_pulse), 32'd0);
    step(1);
    check_eq("to_pulse", 32'(timeout_pulse), 32'd1);
    check_eq("to_ovr", 32'(manual_override), 32'd0);
    check_eq("to_st", 32'(manual_state), 32'd0);
    step(1);
    check_eq("to_pulse_end", 32'(timeout_pulse), 32'd0);
    step(3);
    check_eq("to_count", 32'(to_cnt - to_base), 32'd1);

    // Presses every 25 cycles keep manual mode alive
    to_base = to_cnt;
    btn_mode = 1'b1; step(7);
    btn_mode = 1'b0; step(6);
    step(12);
    press(1'b0, 1'b1, "keep1", 1'b1, 2'b01);
    step(12);
    press(1'b0, 1'b1, "keep2", 1'b1, 2'b10);
    check_eq("keep_no_to", 32'(to_cnt - to_base), 32'd0);

    // Asynchronous reset mid-timeout in state 10
    step(8);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_ovr", 32'(manual_override), 32'd0);
    check_eq("arst_st", 32'(manual_state), 32'd0);
    step(2);
    reset = 1'b0;
    to_base = to_cnt;
    step(40);
    check_eq("arst_no_to", 32'(to_cnt - to_base), 32'd0);
    check_eq("arst_ovr_hold", 32'(manual_override), 32'd0);

    // Button held across reset release gives one event after 7 edges
    reset = 1'b1;
    btn_mode = 1'b1;
    step(2);
    reset = 1'b0;
    step(6);
    check_eq("held_early", 32'(manual_override), 32'd0);
    step(1);
    check_eq("held_ovr", 32'(manual_override), 32'd1);
    step(10);
    check_eq("held_once", 32'(manual_override), 32'd1);
    btn_mode = 1'b0;
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/manual_override_ctrl.md
MANUAL_OVERRIDE_CTRL -- requirements
Module: manual_override_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable clk cycles before a button level is accepted (10 ms at 100 MHz); legal range 1 to 2^24-1.
REQ-002 Parameter TICKS_PER_SEC, default 100000000, clk cycles per one-second timeout tick.
REQ-003 Parameter TIMEOUT_SEC, default 30, seconds without a button press before manual mode auto-releases; 0 disables timeout; legal range 0 to 255.
REQ-004 clk  input  1  system clock, 100 MHz.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 btn_mode  input  1  raw push button (asynchronous, bouncing), toggles manual mode.
REQ-007 btn_next  input  1  raw push button (asynchronous, bouncing), advances the manual light state.
REQ-008 manual_override  output  1  level, 1 while in manual mode; feeds the traffic light controller.
REQ-009 manual_state  output  2  requested light state: 00 red, 01 yellow, 10 green; 11 is never driven.
REQ-010 timeout_pulse  output  1  one-clk pulse when manual mode is released by timeout.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each button SHALL have an independent debouncer: counter increments while the synced level differs from the accepted level and clears otherwise; at DEBOUNCE_CYCLES the accepted level flips and the counter clears.
REQ-013 A press event SHALL be a one-cycle pulse on the accepted level's 0->1 transition; releases generate no event.
REQ-014 Latency from a clean raw 0->1 transition (set up before edge 0) to the output register change SHALL be exactly DEBOUNCE_CYCLES+3 clk edges.
REQ-015 Glitches shorter than DEBOUNCE_CYCLES synced cycles SHALL produce no event.
REQ-016 FSM states SHALL be AUTO and MANUAL; all outputs registered.
REQ-017 AUTO with mode event: go to MANUAL, manual_override=1, manual_state=00, clear timeout counters.
REQ-018 AUTO with next event: ignore it; manual_state holds 00.
REQ-019 MANUAL with next event: manual_state advances 00->01->10->00 and timeout counters clear.
REQ-020 MANUAL with mode event: go to AUTO, manual_override=0, manual_state=00.
REQ-021 Mode and next events in the same cycle SHALL act as a mode event only; the next event is discarded.
REQ-022 Timeout: a prescaler counts 0..TICKS_PER_SEC-1 only in MANUAL; each wrap increments a seconds counter.
REQ-023 On reaching TIMEOUT_SEC, the FSM SHALL go to AUTO, set manual_state=00 and pulse timeout_pulse for one cycle.
REQ-024 A button event in the timeout cycle SHALL take priority; no timeout occurs that cycle and counters clear.
REQ-025 Prescaler and seconds counter SHALL hold at 0 in AUTO.
REQ-026 Outputs SHALL stay stable as levels between events so a slow downstream sampling clock (1 Hz) sees a consistent pair.
REQ-027 manual_state SHALL change only in the same cycle as, or while, manual_override=1, except the forced 00 on exit.

Reset
REQ-028 Reset SHALL clear at once, without waiting for clk: FSM=AUTO, manual_override=0, manual_state=00, timeout_pulse=0, synchronizers and accepted levels=0, all counters=0.
REQ-029 A button held across reset release SHALL produce one event after DEBOUNCE_CYCLES+3 edges.
REQ-030 Reset asserted mid-debounce or mid-timeout SHALL discard partial counts.

Verification (DEBOUNCE_CYCLES=4, TICKS_PER_SEC=10, TIMEOUT_SEC=3)
REQ-031 Clean btn_mode press from reset -> manual_override=1, manual_state=00 exactly 7 edges after the press; no earlier change.
REQ-032 In MANUAL, 4 btn_next presses -> manual_state 01, 10, 00, 01; btn_next presses in AUTO -> manual_state stays 00.
REQ-033 btn_mode pulses of 3 cycles, repeated 3 times with 1-cycle gaps -> no output change.
REQ-034 Enter MANUAL, no presses for 30 cycles -> timeout_pulse high for exactly one cycle, manual_override=0, manual_state=00; presses every 25 cycles -> no timeout.
REQ-035 Both buttons' events in the same cycle while in MANUAL at state 01 -> AUTO, manual_state=00; repeat from AUTO -> MANUAL, state 00.
REQ-036 Reset asserted asynchronously mid-timeout in MANUAL state 10 -> outputs 0/00 immediately; no timeout_pulse afterwards.
